// File: rtl/vector_lane_engine_pkg.sv
// -----------------------------------------------------------------------------
// vector_lane_engine_pkg
// Shared constants for the vector lane engine: element/vector geometry,
// operation codes, FSM state encoding, lane-count limits and a length clamp
// helper. Imported by the interface, the lane ALU and the engine top.
// -----------------------------------------------------------------------------
package vector_lane_engine_pkg;

  // Vector geometry
  localparam int LEN              = 32;  // element width in bits
  localparam int VECTOR_SIZE      = 8;   // elements per vector register
  localparam int ENTRY_INDEX_SIZE = 3;   // log2(VECTOR_SIZE)
  localparam int LW               = ENTRY_INDEX_SIZE + 1;  // width of vl

  // Lane-count sanity limits; the engine clamps its parameter into this range
  localparam int LANE_SIZE_DEFAULT = 2;
  localparam int LANE_SIZE_MIN     = 1;
  localparam int LANE_SIZE_MAX     = VECTOR_SIZE;

  // Operation codes; any code not listed here behaves as OP_ADD
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_MINU   = 4'd5;
  localparam logic [3:0] OP_MAXU   = 4'd6;
  localparam logic [3:0] OP_MIN    = 4'd7;
  localparam logic [3:0] OP_MAX    = 4'd8;
  localparam logic [3:0] OP_REDSUM = 4'd9;

  // Engine FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // vl values above VECTOR_SIZE are treated as VECTOR_SIZE
  function automatic logic [LW-1:0] clamp_length(input logic [LW-1:0] len);
    if (len > LW'(VECTOR_SIZE)) begin
      return LW'(VECTOR_SIZE);
    end
    return len;
  endfunction

endpackage

// File: rtl/vector_lane_engine_if.sv
// -----------------------------------------------------------------------------
// vector_lane_engine_if
// Issue and result bundle between the vector issue stage (master) and the
// vector lane engine (slave).
//
// Handshakes:
//   issue : an instruction transfers on a rising edge where start=1 and
//           ready=1; all operand fields are sampled on that edge only.
//   result: result is stable while result_valid=1 and transfers on a rising
//           edge where result_valid=1 and result_ack=1.
//
// Signals: start, ready, length, op, use_scalar, scalar, vs1, vs2, vd_old,
//          mask, mask_en (issue side); result, result_valid, result_ack
//          (result side).
// -----------------------------------------------------------------------------
interface vector_lane_engine_if;
  import vector_lane_engine_pkg::*;

  logic                        start;
  logic                        ready;
  logic [LW-1:0]               length;
  logic [3:0]                  op;
  logic                        use_scalar;
  logic [LEN-1:0]              scalar;
  logic [VECTOR_SIZE*LEN-1:0]  vs1;
  logic [VECTOR_SIZE*LEN-1:0]  vs2;
  logic [VECTOR_SIZE*LEN-1:0]  vd_old;
  logic [VECTOR_SIZE-1:0]      mask;
  logic                        mask_en;
  logic [VECTOR_SIZE*LEN-1:0]  result;
  logic                        result_valid;
  logic                        result_ack;

  modport master (
    output start, length, op, use_scalar, scalar, vs1, vs2, vd_old,
           mask, mask_en, result_ack,
    input  ready, result, result_valid
  );

  modport slave (
    input  start, length, op, use_scalar, scalar, vs1, vs2, vd_old,
           mask, mask_en, result_ack,
    output ready, result, result_valid
  );

endinterface

// File: rtl/vector_lane_alu.sv
// -----------------------------------------------------------------------------
// vector_lane_alu
// One purely combinational lane of the vector engine.
//
// Ports:
//   vs2_elem  in  LEN  vs2 element handled by this lane
//   op1       in  LEN  second operand (scalar or vs1 element, chosen upstream)
//   op        in  4    operation code
//   active    in  1    lane is in range and not masked off
//   value     out LEN  element result f(vs2_elem, op1)
//   red       out LEN  contribution to the sum reduction (0 when inactive)
// -----------------------------------------------------------------------------
module vector_lane_alu
  import vector_lane_engine_pkg::*;
(
  input  logic [LEN-1:0] vs2_elem,
  input  logic [LEN-1:0] op1,
  input  logic [3:0]     op,
  input  logic           active,
  output logic [LEN-1:0] value,
  output logic [LEN-1:0] red
);

  always_comb begin
    value = vs2_elem + op1;
    case (op)
      OP_ADD:    value = vs2_elem + op1;
      OP_SUB:    value = vs2_elem - op1;
      OP_AND:    value = vs2_elem & op1;
      OP_OR:     value = vs2_elem | op1;
      OP_XOR:    value = vs2_elem ^ op1;
      OP_MINU:   value = (vs2_elem < op1) ? vs2_elem : op1;
      OP_MAXU:   value = (vs2_elem > op1) ? vs2_elem : op1;
      OP_MIN:    value = ($signed(vs2_elem) < $signed(op1)) ? vs2_elem : op1;
      OP_MAX:    value = ($signed(vs2_elem) > $signed(op1)) ? vs2_elem : op1;
      // The reduction never writes elements back; pass vs2 through.
      OP_REDSUM: value = vs2_elem;
      default:   value = vs2_elem + op1;
    endcase
  end

  assign red = active ? vs2_elem : '0;

endmodule

// File: rtl/vector_lane_engine.sv
// -----------------------------------------------------------------------------
// vector_lane_engine
// Multi-lane vector execution unit. Accepts one instruction in IDLE, walks the
// vector LANE_SIZE elements per cycle in RUN, then presents the full
// destination vector in DONE until it is acknowledged. Masked-off and tail
// elements keep vd_old; REDSUM folds active vs2 elements into an accumulator
// seeded with the scalar and writes the sum to element 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   bus        slave modport of vector_lane_engine_if (issue + result)
//   dbg_state  out  current FSM state
// -----------------------------------------------------------------------------
module vector_lane_engine
  import vector_lane_engine_pkg::*;
#(
  parameter int LANE_SIZE = LANE_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_lane_engine_if.slave  bus,
  output state_e               dbg_state
);

  localparam int LANES = (LANE_SIZE < LANE_SIZE_MIN) ? LANE_SIZE_MIN :
                         (LANE_SIZE > LANE_SIZE_MAX) ? LANE_SIZE_MAX : LANE_SIZE;
  // Wide enough for next + lane index and next + LANES without wrapping
  localparam int IW = ENTRY_INDEX_SIZE + 2;
  localparam int VW = VECTOR_SIZE * LEN;

  state_e          state_q, state_d;
  logic [IW-1:0]   next_q, next_d;
  logic [LEN-1:0]  acc_q, acc_d;
  logic [VW-1:0]   result_q, result_d;
  logic [LW-1:0]   len_q, len_d;
  logic [3:0]      op_q, op_d;
  logic            use_scalar_q, use_scalar_d;
  logic            mask_en_q, mask_en_d;
  logic [LEN-1:0]  scalar_q, scalar_d;
  logic [VW-1:0]   vs1_q, vs1_d;
  logic [VW-1:0]   vs2_q, vs2_d;
  logic [VECTOR_SIZE-1:0] mask_q, mask_d;

  logic [IW-1:0]   lane_elem     [LANES];
  logic            lane_in_range [LANES];
  logic            lane_active   [LANES];
  logic [LEN-1:0]  lane_vs2      [LANES];
  logic [LEN-1:0]  lane_op1      [LANES];
  logic [LEN-1:0]  lane_value    [LANES];
  logic [LEN-1:0]  lane_red      [LANES];

  // Route element next+j to lane j. Lanes past the vector end see zeros and
  // are never in range, so they contribute nothing.
  always_comb begin
    logic elem_mask;
    for (int j = 0; j < LANES; j++) begin
      elem_mask        = 1'b0;
      lane_elem[j]     = next_q + IW'(j);
      lane_in_range[j] = lane_elem[j] < IW'(len_q);
      lane_vs2[j]      = '0;
      lane_op1[j]      = scalar_q;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        if (lane_elem[j] == IW'(i)) begin
          lane_vs2[j] = vs2_q[i*LEN +: LEN];
          if (!use_scalar_q) begin
            lane_op1[j] = vs1_q[i*LEN +: LEN];
          end
          elem_mask = mask_q[i];
        end
      end
      lane_active[j] = lane_in_range[j] && (!mask_en_q || elem_mask);
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    vector_lane_alu u_alu (
      .vs2_elem (lane_vs2[j]),
      .op1      (lane_op1[j]),
      .op       (op_q),
      .active   (lane_active[j]),
      .value    (lane_value[j]),
      .red      (lane_red[j])
    );
  end

  always_comb begin
    logic [LEN-1:0] red_sum;
    state_d      = state_q;
    next_d       = next_q;
    acc_d        = acc_q;
    result_d     = result_q;
    len_d        = len_q;
    op_d         = op_q;
    use_scalar_d = use_scalar_q;
    mask_en_d    = mask_en_q;
    scalar_d     = scalar_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    mask_d       = mask_q;
    red_sum      = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d        = clamp_length(bus.length);
          op_d         = bus.op;
          use_scalar_d = bus.use_scalar;
          mask_en_d    = bus.mask_en;
          scalar_d     = bus.scalar;
          vs1_d        = bus.vs1;
          vs2_d        = bus.vs2;
          mask_d       = bus.mask;
          next_d       = '0;
          acc_d        = bus.scalar;
          // Start from vd_old so masked and tail elements need no extra work
          result_d     = bus.vd_old;
          if (bus.length == '0) begin
            state_d = ST_DONE;
            if (bus.op == OP_REDSUM) begin
              result_d[0 +: LEN] = bus.scalar;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        for (int j = 0; j < LANES; j++) begin
          red_sum = red_sum + lane_red[j];
        end
        if (op_q == OP_REDSUM) begin
          acc_d = red_sum;
        end else begin
          for (int j = 0; j < LANES; j++) begin
            for (int i = 0; i < VECTOR_SIZE; i++) begin
              if (lane_active[j] && (lane_elem[j] == IW'(i))) begin
                result_d[i*LEN +: LEN] = lane_value[j];
              end
            end
          end
        end
        if ((next_q + IW'(LANES)) >= IW'(len_q)) begin
          state_d = ST_DONE;
          if (op_q == OP_REDSUM) begin
            result_d[0 +: LEN] = red_sum;
          end
        end else begin
          next_d = next_q + IW'(LANES);
        end
      end

      ST_DONE: begin
        // start is ignored here; only the acknowledge moves us on
        if (bus.result_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      next_q       <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      len_q        <= '0;
      op_q         <= OP_ADD;
      use_scalar_q <= 1'b0;
      mask_en_q    <= 1'b0;
      scalar_q     <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      next_q       <= next_d;
      acc_q        <= acc_d;
      result_q     <= result_d;
      len_q        <= len_d;
      op_q         <= op_d;
      use_scalar_q <= use_scalar_d;
      mask_en_q    <= mask_en_d;
      scalar_q     <= scalar_d;
      vs1_q        <= vs1_d;
      vs2_q        <= vs2_d;
      mask_q       <= mask_d;
    end
  end

  assign bus.ready        = (state_q == ST_IDLE);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.result       = result_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_vector_lane_engine.sv
// -----------------------------------------------------------------------------
// tb_vector_lane_engine
// Directed bench for vector_lane_engine with LANE_SIZE=2.
// -----------------------------------------------------------------------------
module tb_vector_lane_engine;
  import vector_lane_engine_pkg::*;

  localparam int VW = VECTOR_SIZE * LEN;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     checks = 0;
  int     errors = 0;
  logic [LEN-1:0] exp_q[$];

  vector_lane_engine_if vif();

  vector_lane_engine #(.LANE_SIZE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (vif.slave),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------- drivers
  task automatic set_idle_inputs();
    vif.start      = 1'b0;
    vif.length     = '0;
    vif.op         = OP_ADD;
    vif.use_scalar = 1'b0;
    vif.scalar     = '0;
    vif.vs1        = '0;
    vif.vs2        = '0;
    vif.vd_old     = '0;
    vif.mask       = '0;
    vif.mask_en    = 1'b0;
    vif.result_ack = 1'b0;
  endtask

  // Called at posedge+1 with the engine idle; returns at posedge+1 after the
  // accept edge. Operands are scrambled afterwards so late changes are visible.
  task automatic issue(input logic [LW-1:0] len, input logic [3:0] op,
                       input logic use_s, input logic [LEN-1:0] sc,
                       input logic [VW-1:0] vs1, input logic [VW-1:0] vs2,
                       input logic [VW-1:0] vdo, input logic [VECTOR_SIZE-1:0] m,
                       input logic men);
    vif.length     = len;
    vif.op         = op;
    vif.use_scalar = use_s;
    vif.scalar     = sc;
    vif.vs1        = vs1;
    vif.vs2        = vs2;
    vif.vd_old     = vdo;
    vif.mask       = m;
    vif.mask_en    = men;
    vif.start      = 1'b1;
    @(posedge clk); #1;
    vif.start      = 1'b0;
    vif.length     = LW'($urandom_range(0, 15));
    vif.op         = 4'($urandom_range(0, 15));
    vif.use_scalar = ~use_s;
    vif.scalar     = $urandom();
    vif.mask       = VECTOR_SIZE'($urandom());
    vif.mask_en    = ~men;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vif.vs1[i*LEN +: LEN]    = $urandom();
      vif.vs2[i*LEN +: LEN]    = $urandom();
      vif.vd_old[i*LEN +: LEN] = $urandom();
    end
  endtask

  // edges counts rising edges from the accept edge (inclusive) until
  // result_valid is seen; -1 on timeout.
  task automatic wait_valid(output int edges, output int runs, output bit ready_seen);
    edges = 1;
    runs = 0;
    ready_seen = 1'b0;
    while (vif.result_valid !== 1'b1 && edges < 64) begin
      if (vif.ready !== 1'b0) ready_seen = 1'b1;
      if (dbg_state == ST_RUN) runs++;
      @(posedge clk); #1;
      edges++;
    end
    if (vif.result_valid !== 1'b1) edges = -1;
  endtask

  task automatic do_ack();
    vif.result_ack = 1'b1;
    @(posedge clk); #1;
    vif.result_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0;
    set_idle_inputs();
    #3;
    checks++; if (vif.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", vif.ready); end
    checks++; if (vif.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", vif.result_valid); end
    checks++; if (vif.result !== '0) begin errors++; $display("FAIL reset_result got %h expected 0", vif.result); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (vif.ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b expected 1", vif.ready); end
  endtask

  task automatic test_add();
    logic [VW-1:0] vs1, vs2, vdo;
    logic [LEN-1:0] got, exp;
    int edges, runs;
    bit rs;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vs2[i*LEN +: LEN] = LEN'(i);
      vs1[i*LEN +: LEN] = 32'd10;
      vdo[i*LEN +: LEN] = 32'h5555_0000 + LEN'(i);
      exp_q.push_back(32'd10 + LEN'(i));
    end
    issue(4'd8, OP_ADD, 1'b0, 32'hDEAD_BEEF, vs1, vs2, vdo, 8'h00, 1'b0);
    wait_valid(edges, runs, rs);
    checks++; if (edges !== 5) begin errors++; $display("FAIL add_latency got %0d edges expected 5", edges); end
    checks++; if (runs !== 4) begin errors++; $display("FAIL add_run_cycles got %0d expected 4", runs); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL add_ready_low ready seen high while busy"); end
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      got = vif.result[i*LEN +: LEN];
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL add_elem%0d got %h expected %h", i, got, exp); end
    end
    do_ack();
    checks++; if (vif.ready !== 1'b1) begin errors++; $display("FAIL add_ready_after_ack got %b expected 1", vif.ready); end
  endtask

  task automatic test_sub_scalar_tail();
    logic [VW-1:0] vs1, vs2, vdo;
    logic [LEN-1:0] got, exp;
    int edges, runs;
    bit rs;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vs2[i*LEN +: LEN] = 32'd100;
      vs1[i*LEN +: LEN] = 32'd7;
      vdo[i*LEN +: LEN] = 32'hAAAA_AAAA;
      exp_q.push_back((i < 5) ? 32'd99 : 32'hAAAA_AAAA);
    end
    issue(4'd5, OP_SUB, 1'b1, 32'd1, vs1, vs2, vdo, 8'h00, 1'b0);
    wait_valid(edges, runs, rs);
    checks++; if (edges !== 4) begin errors++; $display("FAIL sub_latency got %0d edges expected 4", edges); end
    checks++; if (runs !== 3) begin errors++; $display("FAIL sub_run_cycles got %0d expected 3", runs); end
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      got = vif.result[i*LEN +: LEN];
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL sub_elem%0d got %h expected %h", i, got, exp); end
    end
    do_ack();
  endtask

  task automatic test_minmax_mask();
    logic [3:0]     ops  [4] = '{OP_MAX, OP_MAXU, OP_MIN, OP_MINU};
    logic [LEN-1:0] exp0 [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [VW-1:0] vs1, vs2, vdo;
    logic [LEN-1:0] got, exp;
    int edges, runs;
    bit rs;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        vs2[i*LEN +: LEN] = LEN'(i * 3);
        vs1[i*LEN +: LEN] = LEN'(i);
        vdo[i*LEN +: LEN] = 32'hD0D0_0000 + LEN'(i);
        exp_q.push_back((i == 0) ? exp0[k] : 32'hD0D0_0000 + LEN'(i));
      end
      vs2[0 +: LEN] = 32'hFFFF_FFFF;
      vs1[0 +: LEN] = 32'h0000_0001;
      issue(4'd8, ops[k], 1'b0, 32'd0, vs1, vs2, vdo, 8'b0000_0001, 1'b1);
      wait_valid(edges, runs, rs);
      checks++; if (edges !== 5) begin errors++; $display("FAIL minmax%0d_latency got %0d expected 5", k, edges); end
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        got = vif.result[i*LEN +: LEN];
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL minmax%0d_elem%0d got %h expected %h", k, i, got, exp); end
      end
      do_ack();
    end
  endtask

  task automatic test_logic_ops();
    logic [3:0]     ops [4] = '{OP_AND, OP_OR, OP_XOR, 4'hF};
    logic [LEN-1:0] expv[4] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'hEFF1_EFF0};
    logic [VW-1:0] vs1, vs2, vdo;
    logic [LEN-1:0] got, exp;
    int edges, runs;
    bit rs;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        vs2[i*LEN +: LEN] = 32'hF0F0_F0F0;
        vs1[i*LEN +: LEN] = 32'hFF00_FF00;
        vdo[i*LEN +: LEN] = 32'h1234_0000 + LEN'(i);
        exp_q.push_back((i < 3) ? expv[k] : 32'h1234_0000 + LEN'(i));
      end
      issue(4'd3, ops[k], 1'b0, 32'd0, vs1, vs2, vdo, 8'h00, 1'b0);
      wait_valid(edges, runs, rs);
      checks++; if (edges !== 3) begin errors++; $display("FAIL logic%0d_latency got %0d expected 3", k, edges); end
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        got = vif.result[i*LEN +: LEN];
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL logic%0d_elem%0d got %h expected %h", k, i, got, exp); end
      end
      do_ack();
    end
  endtask

  task automatic test_redsum();
    logic [LW-1:0]          lens [5] = '{4'd8, 4'd8, 4'd8, 4'd0, 4'd3};
    logic                   mens [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [VECTOR_SIZE-1:0] msks [5] = '{8'b0101_0101, 8'h00, 8'h00, 8'hFF, 8'h00};
    logic [LEN-1:0]         exp0 [5] = '{32'd21, 32'd41, 32'd5, 32'd5, 32'd11};
    int                     lat  [5] = '{5, 5, 5, 1, 3};
    logic [VW-1:0] vs1, vs2, vdo;
    logic [LEN-1:0] got, exp;
    int edges, runs;
    bit rs;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        vs2[i*LEN +: LEN] = LEN'(i + 1);
        vs1[i*LEN +: LEN] = 32'h0BAD_0000;
        vdo[i*LEN +: LEN] = 32'hBEEF_0000 + LEN'(i);
        exp_q.push_back((i == 0) ? exp0[k] : 32'hBEEF_0000 + LEN'(i));
      end
      issue(lens[k], OP_REDSUM, 1'b0, 32'd5, vs1, vs2, vdo, msks[k], mens[k]);
      wait_valid(edges, runs, rs);
      checks++; if (edges !== lat[k]) begin errors++; $display("FAIL redsum%0d_latency got %0d expected %0d", k, edges, lat[k]); end
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        got = vif.result[i*LEN +: LEN];
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL redsum%0d_elem%0d got %h expected %h", k, i, got, exp); end
      end
      do_ack();
    end
  endtask

  task automatic test_length_clamp();
    logic [VW-1:0] vs1, vs2, vdo;
    logic [LEN-1:0] got, exp;
    int edges, runs;
    bit rs;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vs2[i*LEN +: LEN] = LEN'(i);
      vs1[i*LEN +: LEN] = 32'h100;
      vdo[i*LEN +: LEN] = 32'hCCCC_CCCC;
      exp_q.push_back(32'h100 + LEN'(i));
    end
    issue(4'd12, OP_ADD, 1'b0, 32'd0, vs1, vs2, vdo, 8'h00, 1'b0);
    wait_valid(edges, runs, rs);
    checks++; if (edges !== 5) begin errors++; $display("FAIL clamp_latency got %0d expected 5", edges); end
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      got = vif.result[i*LEN +: LEN];
      exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL clamp_elem%0d got %h expected %h", i, got, exp); end
    end
    do_ack();
  endtask

  task automatic test_ack_hold();
    logic [VW-1:0] vs1, vs2, vdo, expv;
    int edges, runs;
    bit rs;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vs2[i*LEN +: LEN]  = LEN'(2 * i);
      vs1[i*LEN +: LEN]  = 32'd1;
      vdo[i*LEN +: LEN]  = 32'h7777_0000 + LEN'(i);
      expv[i*LEN +: LEN] = (i < 2) ? LEN'(2 * i + 1) : 32'h7777_0000 + LEN'(i);
    end
    issue(4'd2, OP_ADD, 1'b0, 32'd0, vs1, vs2, vdo, 8'h00, 1'b0);
    wait_valid(edges, runs, rs);
    checks++; if (edges !== 2) begin errors++; $display("FAIL hold_latency got %0d expected 2", edges); end
    for (int c = 0; c < 10; c++) begin
      vif.start  = 1'b1;
      vif.length = 4'd8;
      vif.op     = OP_SUB;
      vif.vs2    = '1;
      @(posedge clk); #1;
      checks++; if (vif.result_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid got %b expected 1", c, vif.result_valid); end
      checks++; if (vif.result !== expv) begin errors++; $display("FAIL hold%0d_result got %h expected %h", c, vif.result, expv); end
      checks++; if (dbg_state !== ST_DONE) begin errors++; $display("FAIL hold%0d_state got %0d expected %0d", c, dbg_state, ST_DONE); end
    end
    vif.start = 1'b0;
    do_ack();
    checks++; if (vif.ready !== 1'b1) begin errors++; $display("FAIL hold_ready_after_ack got %b expected 1", vif.ready); end
    checks++; if (vif.result_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_after_ack got %b expected 0", vif.result_valid); end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] vs1, vs2, vdo, exp1, exp2;
    int edges, runs, interval;
    bit rs;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vs2[i*LEN +: LEN]  = LEN'(i);
      vs1[i*LEN +: LEN]  = LEN'(i);
      vdo[i*LEN +: LEN]  = 32'h9999_0000 + LEN'(i);
      exp1[i*LEN +: LEN] = (i < 4) ? LEN'(2 * i) : 32'h9999_0000 + LEN'(i);
      exp2[i*LEN +: LEN] = (i < 2) ? LEN'(50 - i) : 32'h9999_0000 + LEN'(i);
    end
    issue(4'd4, OP_ADD, 1'b0, 32'd0, vs1, vs2, vdo, 8'h00, 1'b0);
    wait_valid(edges, runs, rs);
    checks++; if (vif.result !== exp1) begin errors++; $display("FAIL b2b_first_result got %h expected %h", vif.result, exp1); end
    do_ack();
    checks++; if (vif.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b expected 1", vif.ready); end
    for (int i = 0; i < VECTOR_SIZE; i++) vs2[i*LEN +: LEN] = 32'd50;
    issue(4'd2, OP_SUB, 1'b0, 32'd0, vs1, vs2, vdo, 8'h00, 1'b0);
    interval = edges + 1;
    checks++; if (interval !== 4) begin errors++; $display("FAIL b2b_interval got %0d expected 4", interval); end
    checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL b2b_second_accept got state %0d expected %0d", dbg_state, ST_RUN); end
    wait_valid(edges, runs, rs);
    checks++; if (edges !== 2) begin errors++; $display("FAIL b2b_second_latency got %0d expected 2", edges); end
    checks++; if (vif.result !== exp2) begin errors++; $display("FAIL b2b_second_result got %h expected %h", vif.result, exp2); end
    do_ack();
  endtask

  task automatic test_reset_mid_run();
    logic [VW-1:0] vs1, vs2, vdo, expv;
    int edges, runs;
    bit rs;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vs2[i*LEN +: LEN]  = LEN'(i);
      vs1[i*LEN +: LEN]  = 32'h100;
      vdo[i*LEN +: LEN]  = 32'h3333_0000 + LEN'(i);
      expv[i*LEN +: LEN] = (i < 6) ? (32'h100 | LEN'(i)) : 32'h3333_0000 + LEN'(i);
    end
    issue(4'd8, OP_ADD, 1'b0, 32'd0, vs1, vs2, vdo, 8'h00, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    checks++; if (vif.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b expected 1", vif.ready); end
    checks++; if (vif.result_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", vif.result_valid); end
    checks++; if (vif.result !== '0) begin errors++; $display("FAIL midrst_result got %h expected 0", vif.result); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state got %0d expected %0d", dbg_state, ST_IDLE); end
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (vif.result_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_valid got %b expected 0", vif.result_valid); end
    issue(4'd6, OP_OR, 1'b0, 32'd0, vs1, vs2, vdo, 8'h00, 1'b0);
    wait_valid(edges, runs, rs);
    checks++; if (edges !== 4) begin errors++; $display("FAIL midrst_next_latency got %0d expected 4", edges); end
    checks++; if (vif.result !== expv) begin errors++; $display("FAIL midrst_next_result got %h expected %h", vif.result, expv); end
    do_ack();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_add();
    test_sub_scalar_tail();
    test_minmax_mask();
    test_logic_ops();
    test_redsum();
    test_length_clamp();
    test_ack_hold();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_lane_engine.md
# vector_lane_engine

Multi-lane vector execution unit that takes one vector instruction at a time and processes it across LANE_SIZE parallel lanes over ceil(vl/LANE_SIZE) cycles. It adds per-element masking, tail-undisturbed writeback, scalar-operand broadcast, a sum reduction, and a valid/ack result handshake. It sits between the vector issue stage and vector register-file writeback, and is the parametrised successor of the current vector function unit.

## Interface
- LEN, 32: element width in bits.
- VECTOR_SIZE, 8: elements per vector register.
- ENTRY_INDEX_SIZE, 3: log2(VECTOR_SIZE).
- LANE_SIZE, 2: parallel lanes; any value 1..VECTOR_SIZE, not required to divide VECTOR_SIZE.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  issue request; accepted only when ready=1.
- ready  out  1  unit idle and accepting an instruction.
- length  in  ENTRY_INDEX_SIZE+1  vl, 0..VECTOR_SIZE; larger values clamp to VECTOR_SIZE.
- op  in  4  operation code (package constants).
- use_scalar  in  1  operand1 is scalar, not the vs1 element.
- scalar  in  LEN  scalar operand; also the reduction seed.
- vs1, vs2, vd_old  in  VECTOR_SIZE*LEN  sources and old destination value.
- mask  in  VECTOR_SIZE  one bit per element.
- mask_en  in  1  masking active.
- result  out  VECTOR_SIZE*LEN  full destination vector.
- result_valid  out  1  result stable and complete.
- result_ack  in  1  consumer accepts result.

## Operation
- States: IDLE, RUN, DONE. ready=1 only in IDLE.
- IDLE, start=1:
  - Capture all inputs.
  - Set next=0, acc=scalar, result=vd_old.
  - If length>0, go to RUN; if length=0, go to DONE with result=vd_old.
- RUN, each cycle: lane j handles element e=next+j when e<length.
  - Active element (mask_en=0 or mask[e]=1): result[e] = f(vs2[e], op1), with op1 = use_scalar ? scalar : vs1[e].
  - Inactive element: result[e] keeps vd_old[e].
  - Lanes with e>=length are idle.
- RUN termination: if next+LANE_SIZE>=length, go to DONE; otherwise next+=LANE_SIZE.
- Ops:
  - Arithmetic: ADD vs2+op1 and SUB vs2-op1, both mod 2^LEN.
  - Logical: AND, OR, XOR.
  - Min/max: MINU, MAXU unsigned; MIN, MAX two's-complement.
- REDSUM:
  - Each RUN cycle: acc += sum of the vs2 values of active lanes, mod 2^LEN.
  - On entry to DONE: result[0]=acc; elements 1..VECTOR_SIZE-1 = vd_old.
  - All-masked or length=0: result[0]=scalar.
- Tail elements (e>=length) always equal vd_old (tail-undisturbed).
- DONE: result_valid=1 and result held constant until result_ack=1, then IDLE. start is ignored in DONE.
- Undefined op: treated as ADD.

## Timing
- Reset (rst=0), immediately and asynchronously:
  - State IDLE, ready=1, result_valid=0, result=0, next=0, acc=0.
  - Reset mid-RUN or mid-DONE aborts the instruction; no result_valid is produced.
- Accept edge: the rising edge with ready=1 and start=1. ready drops the following cycle.
- Latency:
  - RUN lasts ceil(length/LANE_SIZE) cycles.
  - result_valid rises the cycle after the last RUN cycle: accept + ceil(length/LANE_SIZE) + 1 edges.
  - length=0: result_valid one cycle after accept.
- result_ack in the same cycle result_valid rises completes the transfer that edge; ready=1 on the next cycle.
- Back-to-back minimum issue interval: RUN cycles + 2.
- Inputs are sampled only on the accept edge; later changes have no effect.

## Structure
- Op codes, the state encoding, and lane-count sanity limits go in the shared src/defines.v.
- One sub-module, vector_lane_alu, instantiated LANE_SIZE times via generate. It is purely combinational: (vs2 elem, op1, op, active) -> (value, reduction contribution).
- Sequencing, the accumulator, and writeback stay in vector_lane_engine.

## Test plan
- LANE_SIZE=2, length=8, ADD, vs2[i]=i, vs1[i]=10 -> result[i]=10+i; result_valid at accept+5; ready=0 throughout.
- length=5, SUB with use_scalar, scalar=1, vs2[i]=100, vd_old[i]=0xAAAA_AAAA -> elements 0..4 = 99; elements 5..7 = 0xAAAA_AAAA; 3 RUN cycles.
- MAX vs MAXU, vs2[0]=0xFFFF_FFFF, vs1[0]=1 -> signed gives 1, unsigned gives 0xFFFF_FFFF; mask_en=1 with mask=8'b0000_0001 -> elements 1..7 equal vd_old.
- REDSUM, length=8, scalar=5, vs2[i]=i+1, mask=8'b0101_0101 -> result[0]=5+1+3+5+7=21; other elements = vd_old; length=0 -> result[0]=5, result_valid one cycle after accept.
- result_ack held low for 10 cycles -> result and result_valid stable; start pulses ignored; ack -> ready next cycle, then a new instruction is accepted.
- rst pulsed low in the middle of RUN -> result=0, result_valid=0, ready=1 asynchronously; the next instruction completes normally.
